// File: rtl/boa_fetch_align.sv
// boa_fetch_align: realigns word-aligned 32-bit fetch words into a stream of
// 16-bit (compressed) and 32-bit instructions for decode. A 32-bit
// instruction whose low half is the upper half of one fetch word is parked in
// a carry register and completed with the low half of the following word.
// Compressed halfwords go to an external combinational decompressor through
// dc_comp, and its result is muxed onto o_insn.
module boa_fetch_align #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        redir,
  input  logic [31:0] redir_pc,
  input  logic        f_valid,
  output logic        f_ready,
  input  logic [31:0] f_addr,
  input  logic [31:0] f_data,
  output logic [15:0] dc_comp,
  input  logic [31:0] dc_insn,
  input  logic        dc_valid,
  output logic        o_valid,
  input  logic        o_ready,
  output logic [31:0] o_pc,
  output logic [31:0] o_insn,
  output logic        o_rvc,
  output logic        o_ill
);

  // What the registered word/carry state presents this cycle.
  typedef enum logic [2:0] {
    SEL_NONE     = 3'd0,  // no word registered
    SEL_CARRY    = 3'd1,  // carry + low half of w form a 32-bit instruction
    SEL_RVC      = 3'd2,  // current halfword is a compressed instruction
    SEL_FULL     = 3'd3,  // whole word w is one 32-bit instruction
    SEL_STRADDLE = 3'd4   // upper half starts a 32-bit instruction: park it
  } sel_e;

  // Architectural state
  logic [31:0] w_r;
  logic        w_valid_r;
  logic        w_half_r;
  logic [15:0] c_r;
  logic        c_valid_r;
  logic [31:0] pc_r;
  logic [29:0] exp_w_r;

  // Next-state values
  logic [31:0] w_n;
  logic        w_valid_n;
  logic        w_half_n;
  logic [15:0] c_n;
  logic        c_valid_n;
  logic [31:0] pc_n;
  logic [29:0] exp_w_n;

  // Datapath/control helpers
  logic [15:0] h_s;
  sel_e        sel_s;
  logic        emit_s;
  logic        hs_s;
  logic        move_s;
  logic        retire_s;
  logic        accept_s;
  logic        fresh_s;

  // Bits of the address inputs that alignment makes meaningless.
  logic        unused_s;
  assign unused_s = ^{f_addr[1:0], redir_pc[0]};

  // Pick the current halfword and classify what the state presents.
  always_comb begin
    h_s   = 16'h0000;
    sel_s = SEL_NONE;
    if (w_half_r) begin
      h_s = w_r[31:16];
    end else begin
      h_s = w_r[15:0];
    end
    if (!w_valid_r) begin
      sel_s = SEL_NONE;
    end else if (c_valid_r) begin
      sel_s = SEL_CARRY;
    end else if (h_s[1:0] != 2'b11) begin
      sel_s = SEL_RVC;
    end else if (!w_half_r) begin
      sel_s = SEL_FULL;
    end else begin
      sel_s = SEL_STRADDLE;
    end
  end

  // Drive the decode-side outputs; a redirect suppresses the valid only.
  always_comb begin
    emit_s = 1'b0;
    o_insn = 32'h0000_0000;
    o_rvc  = 1'b0;
    o_ill  = 1'b0;
    case (sel_s)
      SEL_CARRY: begin
        emit_s = 1'b1;
        o_insn = {w_r[15:0], c_r};
      end
      SEL_RVC: begin
        emit_s = 1'b1;
        o_rvc  = 1'b1;
        o_ill  = !dc_valid;
        if (dc_valid) begin
          o_insn = dc_insn;
        end else begin
          o_insn = {16'h0000, h_s};
        end
      end
      SEL_FULL: begin
        emit_s = 1'b1;
        o_insn = w_r;
      end
      SEL_STRADDLE: begin
        emit_s = 1'b0;
      end
      SEL_NONE: begin
        emit_s = 1'b0;
      end
      default: begin
        emit_s = 1'b0;
      end
    endcase
    o_valid = emit_s & !redir;
    if (w_valid_r) begin
      o_pc    = pc_r;
      dc_comp = h_s;
    end else begin
      o_pc    = 32'h0000_0000;
      dc_comp = 16'h0000;
    end
  end

  // Handshake, word retirement and fetch acceptance.
  always_comb begin
    hs_s     = o_valid & o_ready;
    move_s   = (sel_s == SEL_STRADDLE) & !redir;
    // The word is done once its last halfword leaves: a 32-bit word, an
    // upper-half compressed instruction, or the straddle move into carry.
    retire_s = move_s |
               (hs_s & ((sel_s == SEL_FULL) | ((sel_s == SEL_RVC) & w_half_r)));
    f_ready  = !redir & (!w_valid_r | retire_s);
    accept_s = f_valid & f_ready;
    fresh_s  = accept_s & (f_addr[31:2] == exp_w_r);
  end

  // Next-state computation; a redirect overrides every other update.
  always_comb begin
    w_n       = w_r;
    w_valid_n = w_valid_r;
    w_half_n  = w_half_r;
    c_n       = c_r;
    c_valid_n = c_valid_r;
    pc_n      = pc_r;
    exp_w_n   = exp_w_r;
    if (redir) begin
      w_valid_n = 1'b0;
      c_valid_n = 1'b0;
      pc_n      = {redir_pc[31:1], 1'b0};
      w_half_n  = redir_pc[1];
      exp_w_n   = redir_pc[31:2];
    end else begin
      case (sel_s)
        SEL_CARRY: begin
          if (hs_s) begin
            pc_n      = pc_r + 32'd4;
            c_valid_n = 1'b0;
            w_half_n  = 1'b1;
          end else begin
            pc_n      = pc_r;
          end
        end
        SEL_RVC: begin
          if (hs_s) begin
            pc_n     = pc_r + 32'd2;
            w_half_n = !w_half_r;
          end else begin
            pc_n     = pc_r;
          end
        end
        SEL_FULL: begin
          if (hs_s) begin
            pc_n = pc_r + 32'd4;
          end else begin
            pc_n = pc_r;
          end
        end
        SEL_STRADDLE: begin
          // Low half of a 32-bit instruction moves to carry without a handshake.
          c_n       = h_s;
          c_valid_n = 1'b1;
          w_half_n  = 1'b0;
        end
        SEL_NONE: begin
          pc_n = pc_r;
        end
        default: begin
          pc_n = pc_r;
        end
      endcase
      if (fresh_s) begin
        w_n       = f_data;
        w_valid_n = 1'b1;
        exp_w_n   = exp_w_r + 30'd1;
      end else if (retire_s) begin
        w_valid_n = 1'b0;
      end else begin
        w_valid_n = w_valid_r;
      end
    end
  end

  // State register with asynchronous reset to the reset PC.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      w_r       <= 32'h0000_0000;
      w_valid_r <= 1'b0;
      w_half_r  <= RESET_PC[1];
      c_r       <= 16'h0000;
      c_valid_r <= 1'b0;
      pc_r      <= {RESET_PC[31:1], 1'b0};
      exp_w_r   <= RESET_PC[31:2];
    end else begin
      w_r       <= w_n;
      w_valid_r <= w_valid_n;
      w_half_r  <= w_half_n;
      c_r       <= c_n;
      c_valid_r <= c_valid_n;
      pc_r      <= pc_n;
      exp_w_r   <= exp_w_n;
    end
  end

endmodule

// File: tb/tb_boa_fetch_align.sv
// Testbench for boa_fetch_align: directed scenarios with fixed expectations
// plus randomized fetch streams checked against a halfword-stream parser.
module tb_boa_fetch_align;

  logic        clk = 1'b0;
  logic        rst, redir, f_valid, f_ready, dc_valid, o_valid, o_ready, o_rvc, o_ill;
  logic [31:0] redir_pc, f_addr, f_data, dc_insn, o_pc, o_insn;
  logic [15:0] dc_comp;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  logic [31:0] tx_addr[$], tx_data[$];
  logic [31:0] act_pc[$], act_insn[$], exp_pc[$], exp_insn[$];
  logic        act_rvc[$], act_ill[$], exp_rvc[$], exp_ill[$];
  int          act_cyc[$];

  boa_fetch_align #(.RESET_PC(32'h0000_0000)) dut (
    .clk(clk), .rst(rst), .redir(redir), .redir_pc(redir_pc),
    .f_valid(f_valid), .f_ready(f_ready), .f_addr(f_addr), .f_data(f_data),
    .dc_comp(dc_comp), .dc_insn(dc_insn), .dc_valid(dc_valid),
    .o_valid(o_valid), .o_ready(o_ready), .o_pc(o_pc), .o_insn(o_insn),
    .o_rvc(o_rvc), .o_ill(o_ill)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Stand-in decompressor: two real expansions, an arbitrary mapping otherwise,
  // and 0x0000 rejected as illegal.
  function automatic logic [31:0] dc_model(input logic [15:0] h);
    case (h)
      16'h0001: dc_model = 32'h0000_0013;
      16'h4505: dc_model = 32'h0010_0513;
      default:  dc_model = {~h, h ^ 16'h5a5a};
    endcase
  endfunction
  assign dc_insn  = dc_model(dc_comp);
  assign dc_valid = (dc_comp != 16'h0000);

  task automatic clear_q();
    tx_addr.delete(); tx_data.delete();
    act_pc.delete(); act_insn.delete(); act_rvc.delete(); act_ill.delete(); act_cyc.delete();
    exp_pc.delete(); exp_insn.delete(); exp_rvc.delete(); exp_ill.delete();
  endtask

  task automatic do_redirect(input logic [31:0] pc);
    @(negedge clk);
    redir = 1'b1; redir_pc = pc; f_valid = 1'b0; o_ready = 1'b0;
    @(negedge clk);
    redir = 1'b0;
  endtask

  // Offer tx words in order with random gaps, random o_ready; log handshakes.
  task automatic run_stream(input int vld_pct, input int rdy_pct, input int tail);
    int idx = 0;
    int idle = 0;
    int budget = 0;
    while ((idx < tx_addr.size() || idle < tail) && budget < 4000) begin
      @(negedge clk);
      f_valid = (idx < tx_addr.size()) && ($urandom_range(0, 99) < vld_pct);
      if (idx < tx_addr.size()) begin
        f_addr = tx_addr[idx]; f_data = tx_data[idx];
      end else begin
        f_addr = 32'h0; f_data = 32'h0;
      end
      o_ready = ($urandom_range(0, 99) < rdy_pct);
      #1;
      if (o_valid && o_ready) begin
        act_pc.push_back(o_pc); act_insn.push_back(o_insn);
        act_rvc.push_back(o_rvc); act_ill.push_back(o_ill); act_cyc.push_back(cyc);
      end
      if (f_valid && f_ready) idx++;
      if (idx >= tx_addr.size()) idle++;
      budget++;
    end
    n_cmp++;
    if (budget >= 4000) begin
      n_bad++;
      $display("FAIL stream_timeout: words accepted %0d, required %0d", idx, tx_addr.size());
    end
    @(negedge clk);
    f_valid = 1'b0; o_ready = 1'b0;
  endtask

  // Reference: collect the halfwords of in-sequence words, then parse.
  task automatic model_build(input logic [31:0] start_pc);
    logic [29:0] ew;
    logic [15:0] hw[$];
    logic [31:0] pc;
    int k;
    ew = start_pc[31:2];
    foreach (tx_addr[i]) begin
      if (tx_addr[i][31:2] == ew) begin
        hw.push_back(tx_data[i][15:0]);
        hw.push_back(tx_data[i][31:16]);
        ew = ew + 30'd1;
      end
    end
    if (start_pc[1] && hw.size() > 0) void'(hw.pop_front());
    pc = {start_pc[31:1], 1'b0};
    k = 0;
    while (k < hw.size()) begin
      if (hw[k][1:0] != 2'b11) begin
        exp_pc.push_back(pc); exp_rvc.push_back(1'b1);
        exp_ill.push_back(hw[k] == 16'h0000);
        exp_insn.push_back((hw[k] == 16'h0000) ? {16'h0, hw[k]} : dc_model(hw[k]));
        pc = pc + 32'd2; k = k + 1;
      end else if (k + 1 < hw.size()) begin
        exp_pc.push_back(pc); exp_rvc.push_back(1'b0); exp_ill.push_back(1'b0);
        exp_insn.push_back({hw[k+1], hw[k]});
        pc = pc + 32'd4; k = k + 2;
      end else begin
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; redir = 1'b0; redir_pc = 32'h0; f_valid = 1'b0;
    f_addr = 32'h0; f_data = 32'h0; o_ready = 1'b0;
    #12;
    @(negedge clk);
    rst = 1'b0;
    #1;
    n_cmp++; if (o_valid !== 1'b0) begin n_bad++; $display("FAIL reset_o_valid: got %b want 0", o_valid); end
    n_cmp++; if (f_ready !== 1'b1) begin n_bad++; $display("FAIL reset_f_ready: got %b want 1", f_ready); end
    n_cmp++; if ({o_pc, o_insn, o_rvc, o_ill} !== 66'h0) begin n_bad++;
      $display("FAIL reset_fields: pc %h insn %h rvc %b ill %b want zeros", o_pc, o_insn, o_rvc, o_ill); end
    n_cmp++; if (dc_comp !== 16'h0) begin n_bad++; $display("FAIL reset_dc_comp: got %h want 0", dc_comp); end
  endtask

  task automatic test_single_word();
    @(negedge clk);
    f_valid = 1'b1; f_addr = 32'h0; f_data = 32'h0000_0013; o_ready = 1'b0;
    #1;
    n_cmp++; if (f_ready !== 1'b1) begin n_bad++; $display("FAIL single_accept: f_ready %b want 1", f_ready); end
    @(negedge clk);
    f_addr = 32'h4; f_data = 32'h0020_0093; o_ready = 1'b1;
    #1;
    n_cmp++; if ({o_valid, o_pc, o_insn, o_rvc, o_ill} !== {1'b1, 32'h0, 32'h0000_0013, 1'b0, 1'b0}) begin n_bad++;
      $display("FAIL single_out: v %b pc %h insn %h rvc %b want 1 0 00000013 0", o_valid, o_pc, o_insn, o_rvc); end
    n_cmp++; if (f_ready !== 1'b1) begin n_bad++; $display("FAIL single_b2b: f_ready %b want 1", f_ready); end
    @(negedge clk);
    f_valid = 1'b0;
    #1;
    n_cmp++; if ({o_valid, o_pc, o_insn, o_rvc} !== {1'b1, 32'h4, 32'h0020_0093, 1'b0}) begin n_bad++;
      $display("FAIL single_next: v %b pc %h insn %h want 1 4 00200093", o_valid, o_pc, o_insn); end
    @(negedge clk);
    o_ready = 1'b0;
  endtask

  task automatic test_rvc_pair();
    do_redirect(32'h0); clear_q();
    tx_addr.push_back(32'h0); tx_data.push_back(32'h4505_0001);
    run_stream(100, 100, 8);
    n_cmp++;
    if (act_pc.size() != 2) begin n_bad++; $display("FAIL rvc_count: got %0d want 2", act_pc.size()); end
    else begin
      n_cmp++; if ({act_pc[0], act_insn[0], act_rvc[0], act_ill[0]} !== {32'h0, 32'h13, 1'b1, 1'b0}) begin n_bad++;
        $display("FAIL rvc_first: pc %h insn %h rvc %b", act_pc[0], act_insn[0], act_rvc[0]); end
      n_cmp++; if ({act_pc[1], act_insn[1], act_rvc[1], act_ill[1]} !== {32'h2, 32'h0010_0513, 1'b1, 1'b0}) begin n_bad++;
        $display("FAIL rvc_second: pc %h insn %h rvc %b", act_pc[1], act_insn[1], act_rvc[1]); end
    end
  endtask

  task automatic test_straddle();
    do_redirect(32'h0); clear_q();
    tx_addr.push_back(32'h0); tx_data.push_back(32'h0513_0001);
    tx_addr.push_back(32'h4); tx_data.push_back(32'h0001_0010);
    run_stream(100, 100, 8);
    n_cmp++;
    if (act_pc.size() != 3) begin n_bad++; $display("FAIL strad_count: got %0d want 3", act_pc.size()); end
    else begin
      n_cmp++; if ({act_pc[0], act_insn[0], act_rvc[0]} !== {32'h0, 32'h13, 1'b1}) begin n_bad++;
        $display("FAIL strad_0: pc %h insn %h rvc %b", act_pc[0], act_insn[0], act_rvc[0]); end
      n_cmp++; if ({act_pc[1], act_insn[1], act_rvc[1]} !== {32'h2, 32'h0010_0513, 1'b0}) begin n_bad++;
        $display("FAIL strad_1: pc %h insn %h rvc %b", act_pc[1], act_insn[1], act_rvc[1]); end
      n_cmp++; if ({act_pc[2], act_insn[2], act_rvc[2]} !== {32'h6, 32'h13, 1'b1}) begin n_bad++;
        $display("FAIL strad_2: pc %h insn %h rvc %b", act_pc[2], act_insn[2], act_rvc[2]); end
      n_cmp++; if (act_cyc[1] - act_cyc[0] != 2) begin n_bad++;
        $display("FAIL strad_bubble: gap %0d cycles want 2", act_cyc[1] - act_cyc[0]); end
    end
  endtask

  task automatic test_redirect_stale();
    do_redirect(32'h0); clear_q();
    @(negedge clk);
    f_valid = 1'b1; f_addr = 32'h0; f_data = 32'h0000_0013; o_ready = 1'b0;
    @(negedge clk);
    f_valid = 1'b0;
    #1;
    n_cmp++; if (o_valid !== 1'b1) begin n_bad++; $display("FAIL redir_pending: o_valid %b want 1", o_valid); end
    @(negedge clk);
    redir = 1'b1; redir_pc = 32'h0000_0102; o_ready = 1'b1;
    #1;
    n_cmp++; if ({o_valid, f_ready} !== 2'b00) begin n_bad++;
      $display("FAIL redir_cycle: o_valid %b f_ready %b want 0 0", o_valid, f_ready); end
    @(negedge clk);
    redir = 1'b0; o_ready = 1'b0;
    tx_addr.push_back(32'h4);   tx_data.push_back(32'h0000_0013);
    tx_addr.push_back(32'h100); tx_data.push_back(32'h4505_0001);
    run_stream(100, 100, 8);
    n_cmp++;
    if (act_pc.size() != 1) begin n_bad++; $display("FAIL redir_count: got %0d want 1", act_pc.size()); end
    else begin
      n_cmp++; if ({act_pc[0], act_insn[0], act_rvc[0]} !== {32'h102, 32'h0010_0513, 1'b1}) begin n_bad++;
        $display("FAIL redir_out: pc %h insn %h rvc %b want 102 00100513 1", act_pc[0], act_insn[0], act_rvc[0]); end
    end
  endtask

  task automatic test_illegal();
    do_redirect(32'h0); clear_q();
    tx_addr.push_back(32'h0); tx_data.push_back(32'h0001_0000);
    run_stream(100, 100, 8);
    n_cmp++;
    if (act_pc.size() != 2) begin n_bad++; $display("FAIL ill_count: got %0d want 2", act_pc.size()); end
    else begin
      n_cmp++; if ({act_pc[0], act_insn[0], act_rvc[0], act_ill[0]} !== {32'h0, 32'h0, 1'b1, 1'b1}) begin n_bad++;
        $display("FAIL ill_out: pc %h insn %h rvc %b ill %b", act_pc[0], act_insn[0], act_rvc[0], act_ill[0]); end
      n_cmp++; if ({act_pc[1], act_ill[1]} !== {32'h2, 1'b0}) begin n_bad++;
        $display("FAIL ill_next: pc %h ill %b want 2 0", act_pc[1], act_ill[1]); end
    end
  endtask

  task automatic test_stall();
    do_redirect(32'h0);
    @(negedge clk);
    f_valid = 1'b1; f_addr = 32'h0; f_data = 32'h4505_0001; o_ready = 1'b0;
    @(negedge clk);
    f_addr = 32'h4; f_data = 32'h0000_0013;
    for (int i = 0; i < 5; i++) begin
      #1;
      n_cmp++; if ({o_valid, o_pc, o_insn, o_rvc, o_ill, f_ready} !== {1'b1, 32'h0, 32'h13, 1'b1, 1'b0, 1'b0}) begin n_bad++;
        $display("FAIL stall_hold: v %b pc %h insn %h rvc %b f_ready %b", o_valid, o_pc, o_insn, o_rvc, f_ready); end
      @(negedge clk);
    end
    o_ready = 1'b1;
    #1;
    n_cmp++; if ({o_pc, f_ready} !== {32'h0, 1'b0}) begin n_bad++;
      $display("FAIL stall_release: pc %h f_ready %b want 0 0", o_pc, f_ready); end
    @(negedge clk);
    #1;
    n_cmp++; if ({o_pc, o_insn, f_ready} !== {32'h2, 32'h0010_0513, 1'b1}) begin n_bad++;
      $display("FAIL stall_second: pc %h insn %h f_ready %b", o_pc, o_insn, f_ready); end
    @(negedge clk);
    f_valid = 1'b0;
    #1;
    n_cmp++; if ({o_valid, o_pc, o_insn, o_rvc} !== {1'b1, 32'h4, 32'h13, 1'b0}) begin n_bad++;
      $display("FAIL stall_third: v %b pc %h insn %h rvc %b", o_valid, o_pc, o_insn, o_rvc); end
    @(negedge clk);
    o_ready = 1'b0;
  endtask

  task automatic test_wrap();
    do_redirect(32'hFFFF_FFFC); clear_q();
    tx_addr.push_back(32'hFFFF_FFFC); tx_data.push_back(32'h0000_0013);
    tx_addr.push_back(32'h0000_0000); tx_data.push_back(32'h4505_0001);
    run_stream(100, 100, 8);
    n_cmp++;
    if (act_pc.size() != 3) begin n_bad++; $display("FAIL wrap_count: got %0d want 3", act_pc.size()); end
    else begin
      n_cmp++; if ({act_pc[0], act_insn[0], act_rvc[0]} !== {32'hFFFF_FFFC, 32'h13, 1'b0}) begin n_bad++;
        $display("FAIL wrap_0: pc %h insn %h", act_pc[0], act_insn[0]); end
      n_cmp++; if ({act_pc[1], act_pc[2], act_insn[2]} !== {32'h0, 32'h2, 32'h0010_0513}) begin n_bad++;
        $display("FAIL wrap_12: pc %h pc %h insn %h", act_pc[1], act_pc[2], act_insn[2]); end
    end
  endtask

  task automatic test_async_reset();
    do_redirect(32'h0); clear_q();
    @(negedge clk);
    f_valid = 1'b1; f_addr = 32'h0; f_data = 32'h0513_0001; o_ready = 1'b1;
    @(negedge clk);
    f_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    n_cmp++; if ({o_valid, f_ready} !== 2'b01) begin n_bad++;
      $display("FAIL areset_now: o_valid %b f_ready %b want 0 1", o_valid, f_ready); end
    #1 rst = 1'b0;
    tx_addr.push_back(32'h0); tx_data.push_back(32'h0000_0013);
    run_stream(100, 100, 6);
    n_cmp++;
    if (act_pc.size() != 1) begin n_bad++; $display("FAIL areset_count: got %0d want 1", act_pc.size()); end
    else begin
      n_cmp++; if ({act_pc[0], act_insn[0], act_rvc[0]} !== {32'h0, 32'h13, 1'b0}) begin n_bad++;
        $display("FAIL areset_out: pc %h insn %h rvc %b", act_pc[0], act_insn[0], act_rvc[0]); end
    end
  endtask

  task automatic test_random();
    for (int r = 0; r < 8; r++) begin
      logic [31:0] start, ea, rv;
      logic [15:0] hv[2];
      int n;
      rv = $urandom();
      start = {rv[31:2], rv[1], 1'b0};
      ea = {start[31:2], 2'b00};
      do_redirect(start); clear_q();
      for (int i = 0; i < 24; i++) begin
        for (int j = 0; j < 2; j++) begin
          int sel;
          rv = $urandom();
          sel = $urandom_range(0, 9);
          if (sel == 0) hv[j] = 16'h0000;
          else if (sel < 5) hv[j] = {rv[15:2], 2'b11};
          else hv[j] = {rv[15:2], 2'(rv[17:16] % 2'd3)};
        end
        if ($urandom_range(0, 99) < 15) tx_addr.push_back(ea + 32'd4 * $urandom_range(1, 5));
        else begin tx_addr.push_back(ea); ea = ea + 32'd4; end
        tx_data.push_back({hv[1], hv[0]});
      end
      run_stream(70, 60, 30);
      model_build(start);
      n_cmp++;
      if (act_pc.size() != exp_pc.size()) begin n_bad++;
        $display("FAIL rand_count: round %0d got %0d want %0d", r, act_pc.size(), exp_pc.size()); end
      n = (act_pc.size() < exp_pc.size()) ? act_pc.size() : exp_pc.size();
      for (int i = 0; i < n; i++) begin
        n_cmp++;
        if ({act_pc[i], act_insn[i], act_rvc[i], act_ill[i]} !== {exp_pc[i], exp_insn[i], exp_rvc[i], exp_ill[i]}) begin
          n_bad++;
          $display("FAIL rand_insn: round %0d idx %0d got pc %h insn %h rvc %b ill %b want pc %h insn %h rvc %b ill %b",
                   r, i, act_pc[i], act_insn[i], act_rvc[i], act_ill[i], exp_pc[i], exp_insn[i], exp_rvc[i], exp_ill[i]);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_single_word();
    test_rvc_pair();
    test_straddle();
    test_redirect_stale();
    test_illegal();
    test_stall();
    test_wrap();
    test_async_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

endmodule

// File: doc/boa_fetch_align.md
# boa_fetch_align

Instruction-stream realigner between the instruction fetch port and the decode stage. It accepts word-aligned 32-bit fetch words and splits them into a stream of 16-bit (RVC) and 32-bit instructions, including 32-bit instructions that straddle two fetch words. It sequences the compressed-instruction decompressor by driving its halfword input and muxing its result into the output. It tracks the PC of every instruction and handles control-flow redirects.

## Interface
- `RESET_PC`, 32'h0000_0000: PC of the first instruction after reset; bit 0 ignored.
- `clk`  in  1  clock, all state on rising edge
- `rst`  in  1  reset, asynchronous, active-high
- `redir`  in  1  redirect request, single-cycle pulse
- `redir_pc`  in  32  redirect target; bit 0 ignored
- `f_valid`  in  1  fetch word valid
- `f_ready`  out  1  fetch word accepted when `f_valid & f_ready`
- `f_addr`  in  32  fetch word address; bits [1:0] ignored
- `f_data`  in  32  fetch word, little-endian halfwords
- `dc_comp`  out  16  halfword to decompressor
- `dc_insn`  in  32  decompressor result, combinational from `dc_comp`
- `dc_valid`  in  1  decompressor legality flag
- `o_valid`  out  1  instruction valid
- `o_ready`  in  1  instruction consumed when `o_valid & o_ready`
- `o_pc`  out  32  instruction PC
- `o_insn`  out  32  expanded 32-bit instruction
- `o_rvc`  out  1  instruction was 16-bit
- `o_ill`  out  1  16-bit instruction rejected by decompressor

## Operation
- State: word reg `w` + `w_valid` + `w_half` (next halfword index); carry reg `c[15:0]` + `c_valid`; `pc` (PC of next instruction); `exp_w[31:2]` (next expected word address).
- Reset: `w_valid=0`, `c_valid=0`, `w_half=RESET_PC[1]`, `pc=RESET_PC & ~1`, `exp_w=RESET_PC[31:2]`. All outputs 0 while `w_valid=0`.
- Fetch accept: if `f_addr[31:2] != exp_w`, the word is stale and is dropped (accepted, no state change except consumption). Otherwise `w<=f_data`, `w_valid<=1`, `exp_w<=exp_w+1` (mod 2^30, wraps 0x3FFF_FFFF→0).
- `f_ready = !redir & (!w_valid | last half of w consumed this cycle)`.
- Selection when `w_valid` and no redirect, with `h = w_half ? w[31:16] : w[15:0]`:
  - `c_valid`: emit `{w[15:0], c}`, `o_rvc=0`, `pc+=4`, `c_valid<=0`, `w_half<=1`.
  - `h[1:0]!=2'b11`: emit `dc_insn`, `o_rvc=1`, `o_ill=!dc_valid`. If `o_ill` is set, `o_insn={16'h0,h}`. Then `pc+=2` and toggle `w_half`.
  - `w_half=0`: emit `w`, `o_rvc=0`, `pc+=4`, word retired.
  - `w_half=1`: the upper half is the low half of a straddling instruction. Set `c<=h`, `c_valid<=1`, `w_half<=0`, word retired. `o_valid=0`, `pc` unchanged.
- `dc_comp = h` at all times; `o_pc = pc`.
- State advances only on output handshake, or on a straddle move (which needs no handshake).
- Redirect: `o_valid=0` and `f_ready=0` that cycle. Then `w_valid<=0`, `c_valid<=0`, `pc<=redir_pc&~1`, `w_half<=redir_pc[1]`, `exp_w<=redir_pc[31:2]`. Redirect overrides all other updates.
- PC arithmetic is modulo 2^32.

## Timing
- Word accepted in cycle N → first instruction from it has `o_valid=1` in cycle N+1 (registered word, combinational decompress path).
- Straddle costs one bubble cycle for the move, then the combined instruction is valid once the next word is registered.
- Back-to-back words with no bubble when the last half is consumed in the same cycle as the next word is accepted.
- Output fields hold stable while `o_valid & !o_ready`.
- `f_ready` depends combinationally on `o_ready`. `o_valid` has no dependence on `f_valid` or `o_ready`.
- `rst` asserted mid-stream clears everything asynchronously. Any in-progress straddle is lost.

## Test plan
- Reset (`RESET_PC=0`), word 0x00000013 at addr 0 → one output: pc 0x0, insn 0x00000013, rvc 0; next word accepted same cycle as handshake.
- Word 0x45050001 at addr 0 → pc 0x0 insn 0x00000013 rvc 1, then pc 0x2 insn 0x00100513 rvc 1.
- Words 0x05130001 @0, 0x00010010 @4 → pc 0x0 insn 0x00000013; one bubble; pc 0x2 insn 0x00100513 rvc 0; pc 0x6 insn 0x00000013 rvc 1.
- Redirect to 0x102 with word pending; then words @0x004 (stale) and 0x45050001 @0x100 → stale dropped with `f_ready=1`, only output pc 0x102 insn 0x00100513.
- Halfword 0x0000 at pc 0 → `o_ill=1`, `o_rvc=1`, `o_insn=0x00000000`, pc advances to 0x2 on handshake.
- Hold `o_ready=0` for 5 cycles with a valid instruction → outputs stable, `f_ready=0`, no state change. Redirect with `RESET_PC` 0xFFFF_FFFC then two words → `exp_w` wraps to 0.
